fetch_stage: RTL and testbench

Instruction-fetch stage of the five-stage pipelined MIPS core. It holds the PC, drives a wait-state-capable instruction memory, and owns the IF/ID pipeline register. It consumes the decode-stage redirect (PCSrcD, flush, branch target) and the hazard-unit stalls, and feeds InstrD/PCPlus4D to decode. Redirects arriving while a memory access is outstanding are deferred without disturbing the memory address.

---
 rtl/fetch_pkg.sv | 29 ++
 rtl/fetch_stage_if_id_reg.sv | 22 ++
 rtl/fetch_stage.sv | 102 ++++++++++
 tb/tb_fetch_stage.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package fetch_pkg;

    typedef enum logic [1:0] {
        PC_SEQ    = 2'b00,
        PC_BRANCH = 2'b01,
        PC_JUMP   = 2'b10
    } pcsrc_t;

    typedef enum logic {
        RUN   = 1'b0,
        REDIR = 1'b1
    } fetch_state_t;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pcplus4;
        logic        valid;
    } ifid_t;

    // J-type target: upper nibble of the delay-slot PC plus the 26-bit word index.
    function automatic logic [31:0] jump_target(input logic [31:0] pcplus4,
                                                input logic [31:0] instr);
        return {pcplus4[31:28], instr[25:0], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_stage_if_id_reg.sv
// IF/ID pipeline register: enable-gated, with a synchronous clear that loads a bubble.
import fetch_pkg::*;

module if_id_reg (
    input  logic  clk,
    input  logic  reset_n,
    input  logic  en,
    input  logic  clr,
    input  ifid_t d,
    output ifid_t q
);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            q <= '{instr: NOP_INSTR, pcplus4: '0, valid: 1'b0};
        end else if (en) begin
            if (clr) q <= '{instr: NOP_INSTR, pcplus4: '0, valid: 1'b0};
            else     q <= d;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC register, redirect handling against a wait-state
// instruction memory, and the IF/ID pipeline register.
import fetch_pkg::*;

module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [1:0]  PCSrcD,
    input  logic [31:0] PCBranchD,
    input  logic        FlushD,
    input  logic        StallF,
    input  logic        StallD,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        imem_ready,
    output logic [31:0] InstrD,
    output logic [31:0] PCPlus4D,
    output logic        ValidD
);

    fetch_state_t state, state_n;
    logic [31:0]  pcf, pcf_n;
    logic [31:0]  redir_pc, redir_pc_n;
    logic [31:0]  pcplus4f;
    logic [31:0]  target;
    logic         req_q;
    logic         rdy;
    logic         fetch_valid;
    ifid_t        ifid_d, ifid_q;

    assign pcplus4f  = pcf + 32'd4;
    // A ready seen while no request is outstanding (first cycle out of reset) is not a completion.
    assign rdy       = imem_ready & req_q;
    assign target    = (PCSrcD == PC_BRANCH) ? PCBranchD : jump_target(ifid_q.pcplus4, ifid_q.instr);
    assign imem_req  = req_q;
    assign imem_addr = pcf;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state    <= RUN;
            pcf      <= RESET_PC;
            redir_pc <= '0;
            req_q    <= 1'b0;
        end else begin
            state    <= state_n;
            pcf      <= pcf_n;
            redir_pc <= redir_pc_n;
            req_q    <= 1'b1;
        end
    end

    always_comb begin
        state_n     = state;
        pcf_n       = pcf;
        redir_pc_n  = redir_pc;
        fetch_valid = 1'b0;
        if (!StallF) begin
            unique case (state)
                RUN: begin
                    if (PCSrcD == PC_SEQ) begin
                        if (rdy) begin
                            pcf_n       = pcplus4f;
                            fetch_valid = 1'b1;
                        end
                    end else if (rdy) begin
                        pcf_n = target;
                    end else begin
                        // Address must not move mid-access; apply the redirect once it completes.
                        redir_pc_n = target;
                        state_n    = REDIR;
                    end
                end
                REDIR: begin
                    if (rdy) begin
                        pcf_n   = redir_pc;
                        state_n = RUN;
                    end
                end
                default: state_n = RUN;
            endcase
        end
    end

    assign ifid_d = '{instr: imem_rdata, pcplus4: pcplus4f, valid: 1'b1};

    if_id_reg u_if_id_reg (
        .clk     (clk),
        .reset_n (reset_n),
        .en      (~StallD),
        .clr     (FlushD | ~fetch_valid),
        .d       (ifid_d),
        .q       (ifid_q)
    );

    assign InstrD   = ifid_q.instr;
    assign PCPlus4D = ifid_q.pcplus4;
    assign ValidD   = ifid_q.valid;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed self-checking bench for fetch_stage with a behavioural instruction memory.
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [1:0]  PCSrcD;
    logic [31:0] PCBranchD;
    logic        FlushD;
    logic        StallF;
    logic        StallD;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        imem_ready;
    logic [31:0] InstrD;
    logic [31:0] PCPlus4D;
    logic        ValidD;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    // Memory returns addr+0x100, except a J instruction (index 0x10) placed at 0x1000_0004.
    assign imem_rdata = (imem_addr == 32'h1000_0004) ? 32'h0800_0010 : imem_addr + 32'h100;

    fetch_stage #(.RESET_PC(32'h0000_0000)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .PCSrcD     (PCSrcD),
        .PCBranchD  (PCBranchD),
        .FlushD     (FlushD),
        .StallF     (StallF),
        .StallD     (StallD),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_rdata (imem_rdata),
        .imem_ready (imem_ready),
        .InstrD     (InstrD),
        .PCPlus4D   (PCPlus4D),
        .ValidD     (ValidD)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0; PCSrcD = 2'b00; PCBranchD = '0; FlushD = 1'b0;
        StallF = 1'b0; StallD = 1'b0; imem_ready = 1'b1;
        tick(); tick();
        checks++; if (imem_req !== 1'b0) begin failures++; $display("FAIL rst_req: got %b exp 0", imem_req); end
        checks++; if (imem_addr !== 32'h0) begin failures++; $display("FAIL rst_addr: got %h exp 0", imem_addr); end
        checks++; if (InstrD !== 32'h0) begin failures++; $display("FAIL rst_instr: got %h exp 0", InstrD); end
        checks++; if (PCPlus4D !== 32'h0) begin failures++; $display("FAIL rst_pcp4: got %h exp 0", PCPlus4D); end
        checks++; if (ValidD !== 1'b0) begin failures++; $display("FAIL rst_valid: got %b exp 0", ValidD); end
        reset_n = 1'b1;
        tick();
        checks++; if (imem_req !== 1'b1) begin failures++; $display("FAIL post_rst_req: got %b exp 1", imem_req); end
        checks++; if (imem_addr !== 32'h0 || ValidD !== 1'b0) begin failures++; $display("FAIL post_rst_first: addr %h valid %b exp 0/0", imem_addr, ValidD); end
    endtask

    task automatic test_zero_wait();
        logic [31:0] exp_addr [2] = '{32'h4, 32'h8};
        logic [31:0] exp_inst [2] = '{32'h100, 32'h104};
        for (int i = 0; i < 2; i++) begin
            tick();
            checks++;
            if (imem_addr !== exp_addr[i] || InstrD !== exp_inst[i] || PCPlus4D !== exp_addr[i] || ValidD !== 1'b1) begin
                failures++;
                $display("FAIL seq_%0d: addr %h instr %h pcp4 %h valid %b exp %h %h %h 1",
                         i, imem_addr, InstrD, PCPlus4D, ValidD, exp_addr[i], exp_inst[i], exp_addr[i]);
            end
        end
    endtask

    task automatic test_wait_states();
        imem_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (imem_addr !== 32'h8 || ValidD !== 1'b0) begin
                failures++;
                $display("FAIL wait_%0d: addr %h valid %b exp 00000008 0", i, imem_addr, ValidD);
            end
        end
        imem_ready = 1'b1;
        tick();
        checks++;
        if (InstrD !== 32'h108 || PCPlus4D !== 32'hC || ValidD !== 1'b1 || imem_addr !== 32'hC) begin
            failures++;
            $display("FAIL wait_done: instr %h pcp4 %h valid %b addr %h exp 108 c 1 c", InstrD, PCPlus4D, ValidD, imem_addr);
        end
    endtask

    task automatic test_branch();
        PCSrcD = 2'b01; PCBranchD = 32'h40; FlushD = 1'b1;
        tick();
        PCSrcD = 2'b00; FlushD = 1'b0;
        checks++;
        if (imem_addr !== 32'h40 || ValidD !== 1'b0) begin
            failures++;
            $display("FAIL br_redirect: addr %h valid %b exp 00000040 0", imem_addr, ValidD);
        end
        tick();
        checks++;
        if (InstrD !== 32'h140 || PCPlus4D !== 32'h44 || ValidD !== 1'b1) begin
            failures++;
            $display("FAIL br_target: instr %h pcp4 %h valid %b exp 140 44 1", InstrD, PCPlus4D, ValidD);
        end
    endtask

    task automatic test_jump_during_wait();
        PCSrcD = 2'b01; PCBranchD = 32'h1000_0004; FlushD = 1'b1;
        tick();
        PCSrcD = 2'b00; FlushD = 1'b0;
        tick();
        checks++;
        if (InstrD !== 32'h0800_0010 || PCPlus4D !== 32'h1000_0008 || imem_addr !== 32'h1000_0008) begin
            failures++;
            $display("FAIL jmp_setup: instr %h pcp4 %h addr %h exp 08000010 10000008 10000008", InstrD, PCPlus4D, imem_addr);
        end
        imem_ready = 1'b0; PCSrcD = 2'b10; FlushD = 1'b1;
        tick();
        checks++;
        if (imem_addr !== 32'h1000_0008 || ValidD !== 1'b0) begin
            failures++;
            $display("FAIL jmp_hold0: addr %h valid %b exp 10000008 0", imem_addr, ValidD);
        end
        // Redirect still asserted in the deferred state must be ignored.
        tick();
        PCSrcD = 2'b00; FlushD = 1'b0;
        checks++;
        if (imem_addr !== 32'h1000_0008 || ValidD !== 1'b0) begin
            failures++;
            $display("FAIL jmp_hold1: addr %h valid %b exp 10000008 0", imem_addr, ValidD);
        end
        imem_ready = 1'b1;
        tick();
        checks++;
        if (imem_addr !== 32'h1000_0040 || ValidD !== 1'b0) begin
            failures++;
            $display("FAIL jmp_target: addr %h valid %b exp 10000040 0", imem_addr, ValidD);
        end
        tick();
        checks++;
        if (InstrD !== 32'h1000_0140 || PCPlus4D !== 32'h1000_0044 || ValidD !== 1'b1) begin
            failures++;
            $display("FAIL jmp_first: instr %h pcp4 %h valid %b exp 10000140 10000044 1", InstrD, PCPlus4D, ValidD);
        end
    endtask

    task automatic test_stall();
        StallF = 1'b1; StallD = 1'b1; FlushD = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick();
            checks++;
            if (imem_addr !== 32'h1000_0044 || InstrD !== 32'h1000_0140 || PCPlus4D !== 32'h1000_0044 || ValidD !== 1'b1) begin
                failures++;
                $display("FAIL stall_%0d: addr %h instr %h pcp4 %h valid %b exp 10000044 10000140 10000044 1",
                         i, imem_addr, InstrD, PCPlus4D, ValidD);
            end
            FlushD = 1'b0;
        end
        StallF = 1'b0; StallD = 1'b0;
        tick();
        checks++;
        if (InstrD !== 32'h1000_0144 || PCPlus4D !== 32'h1000_0048 || imem_addr !== 32'h1000_0048) begin
            failures++;
            $display("FAIL stall_release: instr %h pcp4 %h addr %h exp 10000144 10000048 10000048", InstrD, PCPlus4D, imem_addr);
        end
        tick();
        checks++;
        if (InstrD !== 32'h1000_0148 || ValidD !== 1'b1) begin
            failures++;
            $display("FAIL stall_next: instr %h valid %b exp 10000148 1", InstrD, ValidD);
        end
    endtask

    task automatic test_reset_in_redir();
        imem_ready = 1'b0; PCSrcD = 2'b01; PCBranchD = 32'h200; FlushD = 1'b1;
        tick();
        checks++;
        if (imem_addr !== 32'h1000_004C) begin
            failures++;
            $display("FAIL redir_enter: addr %h exp 1000004c", imem_addr);
        end
        reset_n = 1'b0; PCSrcD = 2'b00; FlushD = 1'b0;
        tick();
        checks++;
        if (imem_addr !== 32'h0 || imem_req !== 1'b0 || ValidD !== 1'b0 || InstrD !== 32'h0) begin
            failures++;
            $display("FAIL redir_rst: addr %h req %b valid %b instr %h exp 0 0 0 0", imem_addr, imem_req, ValidD, InstrD);
        end
        reset_n = 1'b1; imem_ready = 1'b1;
        tick();
        tick();
        checks++;
        if (imem_addr !== 32'h4 || InstrD !== 32'h100 || ValidD !== 1'b1) begin
            failures++;
            $display("FAIL redir_discard: addr %h instr %h valid %b exp 4 100 1", imem_addr, InstrD, ValidD);
        end
    endtask

    task automatic test_wrap();
        PCSrcD = 2'b01; PCBranchD = 32'hFFFF_FFFC; FlushD = 1'b1;
        tick();
        PCSrcD = 2'b00; FlushD = 1'b0;
        tick();
        checks++;
        if (InstrD !== 32'h0000_00FC || PCPlus4D !== 32'h0 || imem_addr !== 32'h0 || ValidD !== 1'b1) begin
            failures++;
            $display("FAIL wrap: instr %h pcp4 %h addr %h valid %b exp fc 0 0 1", InstrD, PCPlus4D, imem_addr, ValidD);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_zero_wait();
        test_wait_states();
        test_branch();
        test_jump_during_wait();
        test_stall();
        test_reset_in_redir();
        test_wrap();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
